mfd_trans_fab_arb: RTL and testbench

Packet arbiter sharing the single MSI fabric master port of the MFD transaction cluster between its transaction requesters (the transaction engine, the LBA engine, and any further ones). It grants the port to one requester per packet using round-robin priority. It holds the grant until that packet's last beat is accepted, and passes beats straight through with a valid/ready handshake. An optional watchdog stops a stalled requester from locking the fabric.

---
 rtl/mfd_trans_fab_arb.sv | 168 ++++++++++++++++
 tb/tb_mfd_trans_fab_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfd_trans_fab_arb.sv
// Round-robin packet arbiter for the MFD transaction cluster's single MSI fabric master port.
// Define MFD_TRANS_FAB_ARB_WATCHDOG_EN to build the stall watchdog (counter, ABORT poison beat, timeout_err).
module mfd_trans_fab_arb #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 1,
    parameter int TO_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fab_valid,
    output logic [DATA_W-1:0]         fab_data,
    output logic                      fab_last,
    output logic [SRC_W-1:0]          fab_src,
    input  logic                      fab_ready,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_GRANT  = 2'd1;
`ifdef MFD_TRANS_FAB_ARB_WATCHDOG_EN
    localparam logic [1:0]       ST_ABORT  = 2'd2;
    localparam logic [TO_W-1:0]  TO_LIMIT  = '1;
`endif
    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || SRC_W < 1 || SRC_W < $clog2(NUM_REQ) || TO_W < 1) begin : g_bad_params
        $error("mfd_trans_fab_arb: illegal parameter combination");
    end

    logic [1:0]       state_q, state_d;
    logic [SRC_W-1:0] g_q, g_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [SRC_W-1:0] pick;
    logic             any_req;
    logic [31:0]      idx;
    logic [31:0]      gi;
    logic             sel_valid;
    logic             sel_last;
    logic [DATA_W-1:0] sel_data;
    logic             xfer;
    logic             stall_hit;

    assign gi        = 32'(g_q);
    assign sel_valid = req_valid[gi];
    assign sel_last  = req_last[gi];
    assign sel_data  = req_data[gi*DATA_W +: DATA_W];
    assign xfer      = (state_q == ST_GRANT) && sel_valid && fab_ready;
    assign busy      = (state_q != ST_IDLE);

    // First asserted requester scanning upward from last_grant+1, wrapping.
    always_comb begin
        pick    = last_grant_q;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_grant_d = last_grant_q;
        req_ready    = '0;
        fab_valid    = 1'b0;
        fab_data     = '0;
        fab_last     = 1'b0;
        fab_src      = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    g_d     = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                fab_valid     = sel_valid;
                fab_data      = sel_data;
                fab_last      = sel_last;
                fab_src       = g_q;
                req_ready[gi] = fab_ready;
                if (xfer && sel_last) begin
                    last_grant_d = g_q;
                    state_d      = ST_IDLE;
                end else if (stall_hit) begin
`ifdef MFD_TRANS_FAB_ARB_WATCHDOG_EN
                    state_d = ST_ABORT;
`endif
                end
            end
`ifdef MFD_TRANS_FAB_ARB_WATCHDOG_EN
            ST_ABORT: begin
                fab_valid = 1'b1;
                fab_last  = 1'b1;
                fab_data  = '1;
                fab_src   = g_q;
                if (fab_ready) begin
                    last_grant_d = g_q;
                    state_d      = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            g_q          <= '0;
            last_grant_q <= LAST_INIT;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef MFD_TRANS_FAB_ARB_WATCHDOG_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Only requester silence counts; fabric backpressure with valid high never advances the counter.
    always_comb begin
        cnt_d     = cnt_q;
        stall_hit = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_GRANT) begin
            if (xfer) begin
                cnt_d = '0;
            end else if (!sel_valid) begin
                if (cnt_q != TO_LIMIT) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
                stall_hit = (cnt_d == TO_LIMIT);
            end
        end
        timeout_err_d = stall_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign stall_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mfd_trans_fab_arb.sv
// Scoreboard bench for mfd_trans_fab_arb: per-requester expected beats plus expected grant order.
module tb_mfd_trans_fab_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        fab_valid;
    logic [31:0] fab_data;
    logic        fab_last;
    logic [0:0]  fab_src;
    logic        fab_ready;
    logic        busy;
    logic        timeout_err;

    mfd_trans_fab_arb #(
        .NUM_REQ(2),
        .DATA_W (32),
        .SRC_W  (1),
        .TO_W   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fab_valid  (fab_valid),
        .fab_data   (fab_data),
        .fab_last   (fab_last),
        .fab_src    (fab_src),
        .fab_ready  (fab_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    logic [32:0] rq0[$], rq1[$];
    logic [32:0] ex0[$], ex1[$];
    int unsigned src_exp[$];
    logic        en0, en1, acc0, acc1, toggle_ready;
    int          xfers;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit drained();
        return rq0.size() == 0 && rq1.size() == 0 && ex0.size() == 0 &&
               ex1.size() == 0 && src_exp.size() == 0;
    endfunction

    task automatic load(input int unsigned r, input int unsigned n, input logic [31:0] base, input bit to_sb);
        for (int unsigned k = 0; k < n; k++) begin
            logic [32:0] b;
            b = {(k == n - 1) ? 1'b1 : 1'b0, base + 32'(k)};
            if (r == 0) rq0.push_back(b); else rq1.push_back(b);
            if (to_sb) begin
                if (r == 0) ex0.push_back(b); else ex1.push_back(b);
                src_exp.push_back(r);
            end
        end
    endtask

    task automatic drive_inputs();
        logic [32:0] h0, h1;
        h0 = (rq0.size() != 0) ? rq0[0] : 33'd0;
        h1 = (rq1.size() != 0) ? rq1[0] : 33'd0;
        req_valid = {en1 && (rq1.size() != 0), en0 && (rq0.size() != 0)};
        req_data  = {h1[31:0], h0[31:0]};
        req_last  = {h1[32], h0[32]};
    endtask

    task automatic neg();
        logic [32:0] e;
        int unsigned s;
        @(negedge clk);
        acc0 = req_valid[0] & req_ready[0];
        acc1 = req_valid[1] & req_ready[1];
        if (fab_valid && fab_ready) begin
            xfers++;
            chk("order_avail", 64'(src_exp.size() != 0), 64'd1);
            if (src_exp.size() != 0) begin
                s = src_exp.pop_front();
                chk("fab_src", 64'(fab_src), 64'(s));
            end
            if (fab_src == 1'b0) begin
                chk("exp0_avail", 64'(ex0.size() != 0), 64'd1);
                if (ex0.size() != 0) begin
                    e = ex0.pop_front();
                    chk("beat_r0", 64'({fab_last, fab_data}), 64'(e));
                end
            end else begin
                chk("exp1_avail", 64'(ex1.size() != 0), 64'd1);
                if (ex1.size() != 0) begin
                    e = ex1.pop_front();
                    chk("beat_r1", 64'({fab_last, fab_data}), 64'(e));
                end
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
        if (acc0) void'(rq0.pop_front());
        if (acc1) void'(rq1.pop_front());
        if (toggle_ready) fab_ready = ~fab_ready;
        drive_inputs();
    endtask

    task automatic run_until(input int max, input string tag);
        int n = 0;
        while (!drained() && n < max) begin
            neg();
            pos();
            n++;
        end
        chk(tag, 64'(drained()), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] eb;
        int n;
        int bad;
        reset_n = 1'b0; fab_ready = 1'b0; en0 = 1'b1; en1 = 1'b1;
        toggle_ready = 1'b0; xfers = 0; acc0 = 1'b0; acc1 = 1'b0;
        drive_inputs();
        #1;
        chk("reset_outs", 64'({req_ready, fab_valid, fab_data, fab_last, fab_src, busy, timeout_err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Both requesting 3-beat packets: r0 first, one bubble, then r1.
        fab_ready = 1'b1;
        load(0, 3, 32'hA000_0000, 1);
        load(1, 3, 32'hB000_0000, 1);
        drive_inputs();
        eb = 9'h0EE;
        for (int c = 0; c < 9; c++) begin
            neg();
            chk("busy_seq", 64'(busy), 64'(eb[c]));
            if (!eb[c]) chk("bubble_valid", 64'(fab_valid), 64'd0);
            pos();
        end
        chk("t1_drained", 64'(drained()), 64'd1);

        // Single-beat packets from both: grants must alternate.
        for (int unsigned k = 0; k < 3; k++) begin
            load(0, 1, 32'hC100_0000 + 32'(k), 1);
            load(1, 1, 32'hC200_0000 + 32'(k), 1);
        end
        drive_inputs();
        run_until(40, "t2_done");

        // 4-beat packet under toggling fabric backpressure.
        load(0, 4, 32'hD000_0000, 1);
        drive_inputs();
        xfers = 0;
        toggle_ready = 1'b1;
        n = 0;
        while (!drained() && n < 30) begin
            neg();
            if (busy) chk("rdy_mirror", 64'(req_ready), 64'({1'b0, fab_ready}));
            pos();
            n++;
        end
        chk("t3_done", 64'(drained()), 64'd1);
        chk("t3_xfers", 64'(xfers), 64'd4);
        toggle_ready = 1'b0;
        fab_ready = 1'b1;

        // Requester stalls after its first beat.
`ifdef MFD_TRANS_FAB_ARB_WATCHDOG_EN
        load(0, 3, 32'hE000_0000, 0);
        ex0.push_back({1'b0, 32'hE000_0000});
        src_exp.push_back(0);
        ex0.push_back({1'b1, 32'hFFFF_FFFF});
        src_exp.push_back(0);
        drive_inputs();
        xfers = 0; n = 0;
        while (xfers == 0 && n < 10) begin neg(); pos(); n++; end
        chk("t4_first_beat", 64'(xfers), 64'd1);
        en0 = 1'b0; fab_ready = 1'b0;
        drive_inputs();
        n = 0;
        while (n < 40) begin
            neg();
            if (timeout_err) break;
            pos();
            n++;
        end
        chk("wd_latency", 64'(n), 64'd15);
        chk("poison", 64'({fab_valid, fab_last, fab_data, fab_src}), 64'({1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0}));
        pos();
        neg();
        chk("to_pulse_width", 64'(timeout_err), 64'd0);
        chk("abort_hold", 64'(fab_valid), 64'd1);
        pos();
        fab_ready = 1'b1;
        neg();
        pos();
        neg();
        chk("abort_exit_busy", 64'(busy), 64'd0);
        chk("t4_sb_empty", 64'(ex0.size() + src_exp.size()), 64'd0);
        rq0.delete();
        en0 = 1'b1;
        pos();
`else
        load(0, 3, 32'hE000_0000, 1);
        drive_inputs();
        xfers = 0; n = 0;
        while (xfers == 0 && n < 10) begin neg(); pos(); n++; end
        chk("t4_first_beat", 64'(xfers), 64'd1);
        en0 = 1'b0;
        drive_inputs();
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            neg();
            if (busy !== 1'b1 || fab_valid !== 1'b0 || timeout_err !== 1'b0) bad++;
            pos();
        end
        chk("stall_hold", 64'(bad), 64'd0);
        en0 = 1'b1;
        drive_inputs();
        run_until(20, "t4_resume");
        chk("t4_xfers", 64'(xfers), 64'd3);
`endif

        // Reset while beat 2 of a packet is presented.
        load(1, 4, 32'hF000_0000, 1);
        drive_inputs();
        xfers = 0; n = 0;
        while (xfers == 0 && n < 10) begin neg(); pos(); n++; end
        chk("t5_pre_busy", 64'({busy, fab_valid}), 64'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_mid", 64'({req_ready, fab_valid, fab_data, fab_last, fab_src, busy, timeout_err}), 64'd0);
        rq1.delete(); ex1.delete(); src_exp.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        load(0, 1, 32'h1234_0000, 1);
        load(1, 1, 32'h1234_0001, 1);
        drive_inputs();
        run_until(20, "t5_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
